// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared widths and FSM state codes for the ADC SPI arbiter
package adc_spi_pkg;
  localparam int SPI_WW = 24;
  localparam int SPI_RW = 8;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3
  } state_t;
endpackage

// File: rtl/adc_spi_rr_pick.sv
// adc_spi_rr_pick: combinational round-robin pick of the first active request at or after ptr
// Ports: req_i request vector, ptr_i scan start index, valid_o any request, idx_o chosen index
module adc_spi_rr_pick
  import adc_spi_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [2:0]       ptr_i,
  output logic             valid_o,
  output logic [2:0]       idx_o
);
  logic [N_REQ-1:0] rot;
  int s;
  always_comb begin
    rot = N_REQ'({req_i, req_i} >> ptr_i);
    valid_o = 1'b0;
    idx_o = '0;
    s = 0;
    // Descending scan so the smallest offset from ptr_i is the last writer and wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        s = int'(ptr_i) + k;
        valid_o = 1'b1;
        idx_o = 3'(s >= N_REQ ? s - N_REQ : s);
      end
    end
  end
endmodule

// File: rtl/adc_spi_arb.sv
// adc_spi_arb: round-robin arbiter sharing one ADC SPI master among N_REQ requesters
// Ports: clk/rst (async active-high); req/req_wr_data/ack/rd_data requester side;
//        spi_req/spi_wr_data/spi_ack/spi_rd_data master side; grant/busy/state/err_timeout status.
// Optional feature: define ADC_SPI_ARB_TIMEOUT_EN to abort S_REQ after TIMEOUT cycles.
module adc_spi_arb
  import adc_spi_pkg::*;
#(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [SPI_WW*N_REQ-1:0] req_wr_data,
  output logic [N_REQ-1:0]        ack,
  output logic [SPI_RW-1:0]       rd_data,
  output logic                    spi_req,
  output logic [SPI_WW-1:0]       spi_wr_data,
  input  logic                    spi_ack,
  input  logic [SPI_RW-1:0]       spi_rd_data,
  output logic [2:0]              grant,
  output logic                    busy,
  output logic [2:0]              state,
  output logic                    err_timeout
);
  localparam logic [N_REQ-1:0] lsb = N_REQ'(1);
  localparam int unused_timeout = TIMEOUT;
  state_t             state_q;
  logic [2:0]         grant_q, rr_q, rr_d, pick_idx;
  logic [N_REQ-1:0]   ack_q, gsel;
  logic [SPI_RW-1:0]  rd_q;
  logic [SPI_WW-1:0]  wr_q, pick_word;
  logic               spi_req_q, first_q, pick_valid, req_g;
`ifdef ADC_SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]      cnt_q;
  logic               err_q;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif
  adc_spi_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (req),
    .ptr_i   (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );
  always_comb begin
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++)
      if (pick_idx == 3'(i)) pick_word = req_wr_data[SPI_WW*i +: SPI_WW];
  end
  assign gsel  = lsb << grant_q;
  assign req_g = |(req & gsel);
  assign rr_d  = (grant_q == 3'(N_REQ - 1)) ? 3'd0 : grant_q + 3'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      ack_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      spi_req_q <= 1'b0;
      first_q   <= 1'b0;
`ifdef ADC_SPI_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
`ifdef ADC_SPI_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: if (pick_valid) begin
          grant_q   <= pick_idx;
          wr_q      <= pick_word;
          spi_req_q <= 1'b1;
          first_q   <= 1'b1;
`ifdef ADC_SPI_ARB_TIMEOUT_EN
          cnt_q     <= '0;
`endif
          state_q   <= S_REQ;
        end
        S_REQ: begin
          // first_q masks an spi_ack left over from the previous transaction.
          first_q <= 1'b0;
`ifdef ADC_SPI_ARB_TIMEOUT_EN
          cnt_q   <= cnt_q + 1'b1;
`endif
          if (spi_ack && !first_q) begin
            spi_req_q <= 1'b0;
            rd_q      <= spi_rd_data;
            ack_q     <= gsel;
            state_q   <= S_HOLD;
          end
`ifdef ADC_SPI_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(TIMEOUT - 1)) begin
            spi_req_q <= 1'b0;
            rd_q      <= '0;
            err_q     <= 1'b1;
            ack_q     <= gsel;
            state_q   <= S_HOLD;
          end
`endif
        end
        S_HOLD: if (!req_g) begin
          ack_q   <= '0;
          state_q <= S_RELEASE;
        end
        S_RELEASE: if (!spi_ack) begin
          rr_q    <= rr_d;
          state_q <= S_IDLE;
        end
        default: begin
          spi_req_q <= 1'b0;
          ack_q     <= '0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end
  assign ack         = ack_q;
  assign rd_data     = rd_q;
  assign spi_req     = spi_req_q;
  assign spi_wr_data = wr_q;
  assign grant       = grant_q;
  assign busy        = state_q != S_IDLE;
  assign state       = state_q;
endmodule

// File: tb/tb_adc_spi_arb.sv
// tb_adc_spi_arb: table-driven and scoreboard checks of the ADC SPI arbiter
module tb_adc_spi_arb;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  req = '0;
  logic [23:0] w [3];
  logic [71:0] req_wr_data;
  logic [2:0]  ack;
  logic [7:0]  rd_data;
  logic        spi_req;
  logic [23:0] spi_wr_data;
  logic        spi_ack = 1'b0;
  logic [7:0]  spi_rd_data = '0;
  logic [2:0]  grant;
  logic        busy;
  logic [2:0]  state;
  logic        err_timeout;

  assign req_wr_data = {w[2], w[1], w[0]};
  always #5 clk = ~clk;

  adc_spi_arb #(.N_REQ(3), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr_data(req_wr_data), .ack(ack),
    .rd_data(rd_data), .spi_req(spi_req), .spi_wr_data(spi_wr_data),
    .spi_ack(spi_ack), .spi_rd_data(spi_rd_data), .grant(grant), .busy(busy),
    .state(state), .err_timeout(err_timeout)
  );

  typedef struct {bit rst_before; logic [2:0] raise; int dly; logic [7:0] rd; logic [2:0] g;} vec_t;
  typedef struct {logic [2:0] g; logic [23:0] word; logic [7:0] rd;} exp_t;
  vec_t tbl [9];
  exp_t sb [$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; spi_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_spi_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = spi_req;
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_spi_req: spi_req never rose at %0t", $time);
    end
  endtask

  task automatic txn(input int dly);
    exp_t e;
    bit ok;
    logic [23:0] orig;
    wait_spi_req(ok);
    e = sb.pop_front();
    if (!ok) return;
    chk("grant", grant, e.g);
    chk("spi_wr_data", spi_wr_data, e.word);
    chk("state_req", state, 1);
    chk("busy", busy, 1);
    orig = w[e.g];
    w[e.g] = ~orig;
    repeat (dly) @(negedge clk);
    chk("ack_early", ack, 0);
    chk("spi_req_held", spi_req, 1);
    spi_ack = 1'b1; spi_rd_data = e.rd;
    @(negedge clk);
    chk("ack", ack, 3'b001 << e.g);
    chk("rd_data", rd_data, e.rd);
    chk("spi_req_low", spi_req, 0);
    chk("state_hold", state, 2);
    chk("wr_stable", spi_wr_data, e.word);
    req[e.g] = 1'b0; spi_ack = 1'b0; w[e.g] = orig;
    @(negedge clk);
    chk("ack_drop", ack, 0);
    chk("state_release", state, 3);
    @(negedge clk);
    chk("state_idle", state, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    w[0] = 24'h401504; w[1] = 24'h123456; w[2] = 24'hABCDEF;
    tbl = '{
      '{1'b1, 3'b001, 20, 8'h04, 3'd0},
      '{1'b1, 3'b111,  3, 8'hA1, 3'd0},
      '{1'b0, 3'b000,  5, 8'hB2, 3'd1},
      '{1'b0, 3'b000,  2, 8'hC3, 3'd2},
      '{1'b0, 3'b101,  4, 8'hD4, 3'd0},
      '{1'b0, 3'b000,  1, 8'hE5, 3'd2},
      '{1'b0, 3'b010,  7, 8'h5A, 3'd1},
      '{1'b0, 3'b011,  2, 8'h66, 3'd0},
      '{1'b0, 3'b000,  3, 8'h77, 3'd1}
    };
    @(negedge clk);
    chk("rst_spi_req", spi_req, 0);
    chk("rst_ack", ack, 0);
    chk("rst_state", state, 0);
    chk("rst_grant", grant, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_wr_data", spi_wr_data, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst_before) do_reset();
      req = req | tbl[i].raise;
      sb.push_back('{tbl[i].g, w[tbl[i].g], tbl[i].rd});
      txn(tbl[i].dly);
    end
    chk("sb_empty", sb.size(), 0);

    do_reset();
    req = 3'b010;
    wait_spi_req(ok);
    chk("drop_grant", grant, 1);
    req = '0;
    repeat (3) @(negedge clk);
    spi_ack = 1'b1; spi_rd_data = 8'h38;
    @(negedge clk);
    chk("drop_ack_pulse", ack, 3'b010);
    chk("drop_rd_data", rd_data, 8'h38);
    @(negedge clk);
    chk("drop_ack_end", ack, 0);
    chk("drop_wait_release", state, 3);
    @(negedge clk);
    chk("drop_still_release", state, 3);
    spi_ack = 1'b0;
    @(negedge clk);
    chk("drop_idle", state, 0);
    repeat (5) @(negedge clk);
    chk("drop_no_rereq", spi_req, 0);
    chk("drop_no_ack", ack, 0);

    do_reset();
    req = 3'b001; spi_ack = 1'b1; spi_rd_data = 8'h99;
    @(negedge clk);
    chk("stale_spi_req", spi_req, 1);
    @(negedge clk);
    chk("stale_ignored_state", state, 1);
    chk("stale_ignored_ack", ack, 0);
    spi_ack = 1'b0;
    repeat (2) @(negedge clk);
    spi_ack = 1'b1; spi_rd_data = 8'h21;
    @(negedge clk);
    chk("stale_then_ack", ack, 3'b001);
    chk("stale_then_rd", rd_data, 8'h21);
    req = '0; spi_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stale_idle", state, 0);

    do_reset();
    req = 3'b010;
    sb.push_back('{3'd1, w[1], 8'h11});
    txn(2);
    req = 3'b001;
    wait_spi_req(ok);
    chk("abort_grant", grant, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_spi_req", spi_req, 0);
    chk("abort_ack", ack, 0);
    chk("abort_state", state, 0);
    chk("abort_grant_rst", grant, 0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    req = 3'b100;
    sb.push_back('{3'd2, w[2], 8'h42});
    txn(3);

    req = 3'b001;
    wait_spi_req(ok);
`ifdef ADC_SPI_ARB_TIMEOUT_EN
    repeat (49) @(negedge clk);
    chk("to_spi_req_49", spi_req, 1);
    chk("to_err_49", err_timeout, 0);
    @(negedge clk);
    chk("to_spi_req_50", spi_req, 0);
    chk("to_err_pulse", err_timeout, 1);
    chk("to_rd_zero", rd_data, 0);
    chk("to_ack", ack, 3'b001);
    req = '0;
    @(negedge clk);
    chk("to_err_end", err_timeout, 0);
    chk("to_ack_end", ack, 0);
    @(negedge clk);
    chk("to_idle", state, 0);
`else
    repeat (70) @(negedge clk);
    chk("nto_spi_req", spi_req, 1);
    chk("nto_err", err_timeout, 0);
    chk("nto_state", state, 1);
    spi_ack = 1'b1; spi_rd_data = 8'h70;
    @(negedge clk);
    chk("nto_ack", ack, 3'b001);
    chk("nto_rd", rd_data, 8'h70);
    req = '0; spi_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("nto_idle", state, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_spi_arb.md
ADC_SPI_ARB -- requirements
Module: adc_spi_arb

Interface
REQ-001 Parameter N_REQ, default 3, number of SPI requesters (2..8).
REQ-002 Parameter TIMEOUT, default 100000, clk cycles allowed from spi_req rise to spi_ack (timeout build only).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester level request, held until its ack.
REQ-006 req_wr_data  input  24*N_REQ  SPI word of requester i at bits [24*i+23:24*i].
REQ-007 ack  output  N_REQ  per-requester ack; rd_data valid while high.
REQ-008 rd_data  output  8  read byte of last completed transaction.
REQ-009 spi_req  output  1  request to the shared ADC SPI master.
REQ-010 spi_wr_data  output  24  word to SPI master, stable while spi_req high.
REQ-011 spi_ack  input  1  SPI master done; spi_rd_data valid while high.
REQ-012 spi_rd_data  input  8  SPI master read byte.
REQ-013 grant  output  3  index of current or last granted requester.
REQ-014 busy  output  1  high in any state except S_IDLE.
REQ-015 state  output  3  current FSM state code.
REQ-016 err_timeout  output  1  one-cycle pulse on timeout (timeout build only, else tied 0).

Function
REQ-017 States SHALL be S_IDLE=0, S_REQ=1, S_HOLD=2, S_RELEASE=3.
REQ-018 S_IDLE: if any req high, pick first high index scanning rr_ptr, rr_ptr+1, ... mod N_REQ; latch grant and spi_wr_data <= that word; go S_REQ.
REQ-019 S_REQ: spi_req SHALL be 1 every cycle; first cycle spi_ack=1 -> spi_req<=0, rd_data<=spi_rd_data, ack[grant]<=1, go S_HOLD.
REQ-020 Latency: spi_req rises 1 cycle after req sampled in S_IDLE; ack rises 1 cycle after spi_ack sampled.
REQ-021 spi_ack high on entry to S_REQ (stale) SHALL be ignored for that first S_REQ cycle.
REQ-022 S_HOLD: ack[grant] held 1 until req[grant]=0; then ack<=0, go S_RELEASE.
REQ-023 S_RELEASE: wait spi_ack=0; then rr_ptr<=(grant+1) mod N_REQ, go S_IDLE.
REQ-024 Only ack[grant] SHALL ever be high; at most one ack bit high at any time.
REQ-025 req[grant] dropped before spi_ack: transaction completes; ack pulses 1 cycle in S_HOLD.
REQ-026 req of non-granted requesters SHALL be ignored until back in S_IDLE; no grant changes mid-transaction.
REQ-027 Simultaneous requests: round-robin; a requester waits at most N_REQ-1 transactions.
REQ-028 req_wr_data changes after grant SHALL NOT affect spi_wr_data.
REQ-029 Illegal state code SHALL return to S_IDLE next cycle with spi_req=0, ack=0.

Reset
REQ-030 rst high SHALL immediately force S_IDLE, spi_req=0, spi_wr_data=0, ack=0, rd_data=0, grant=0, rr_ptr=0, err_timeout=0, counter=0.
REQ-031 rst mid-transaction SHALL abort it; no ack issued for the aborted request.

Configuration
REQ-032 Macro ADC_SPI_ARB_TIMEOUT_EN defined: counter runs in S_REQ; at count TIMEOUT-1 without spi_ack -> spi_req<=0, rd_data<=8'h00, err_timeout pulses 1 cycle, ack[grant]<=1, go S_HOLD.
REQ-033 Macro undefined: no counter, S_REQ waits indefinitely, err_timeout tied 0.

Structure
REQ-034 Package adc_spi_pkg SHALL hold state codes, SPI word width 24, read width 8.
REQ-035 Round-robin pick SHALL be sub-module adc_spi_rr_pick (req vector, rr_ptr in; valid, index out; combinational).

Verification
REQ-036 Single req[0], word 24'h401504, master acks after 20 cycles with 8'h04 -> spi_wr_data=24'h401504, ack[0]=1, rd_data=8'h04, grant=0.
REQ-037 req[0..2] high together, rr_ptr=0 -> service order 0,1,2; then req[0],req[2] again -> order 0,2.
REQ-038 req[1] drops before spi_ack -> ack[1] one-cycle pulse, FSM returns S_IDLE, no second spi_req.
REQ-039 Timeout build, TIMEOUT=50, spi_ack never -> spi_req falls at cycle 50, err_timeout 1 cycle, rd_data=8'h00, ack[grant]=1.
REQ-040 rst asserted in S_REQ -> spi_req=0, ack=0, state=0 same cycle; next req[2] granted first with rr_ptr=0.
